fpu_issue: RTL and testbench

FPU_ISSUE -- requirements
Module: fpu_issue

---
 rtl/fpu_issue.sv | 101 ++++++++++
 tb/tb_fpu_issue.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_issue.sv
// fpu_issue: command FIFO plus IDLE/RUN/HOLD issue FSM between core and FPU, with a registered response slot.
// Optional watchdog enabled by defining FPU_ISSUE_TIMEOUT_EN.
`ifndef FPU_REG_ADDR_WIDTH
`define FPU_REG_ADDR_WIDTH 5
`endif
`ifndef FPU_OP_WIDTH
`define FPU_OP_WIDTH 4
`endif
module fpu_issue #(
  parameter int CMD_DEPTH      = 2,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           cmd_valid,
  output logic                           cmd_ready,
  input  logic [`FPU_REG_ADDR_WIDTH-1:0] cmd_x1,
  input  logic [`FPU_REG_ADDR_WIDTH-1:0] cmd_x2,
  input  logic [`FPU_REG_ADDR_WIDTH-1:0] cmd_y,
  input  logic [`FPU_OP_WIDTH-1:0]       cmd_op,
  input  logic [31:0]                    cmd_data,
  output logic [`FPU_REG_ADDR_WIDTH-1:0] x1,
  output logic [`FPU_REG_ADDR_WIDTH-1:0] x2,
  output logic [`FPU_REG_ADDR_WIDTH-1:0] y,
  output logic [`FPU_OP_WIDTH-1:0]       operation,
  output logic [31:0]                    in_data,
  output logic                           ready,
  input  logic                           valid,
  input  logic [31:0]                    out_data,
  input  logic                           cond,
  output logic                           rsp_valid,
  input  logic                           rsp_ready,
  output logic [31:0]                    rsp_data,
  output logic                           rsp_cond
`ifdef FPU_ISSUE_TIMEOUT_EN
  ,
  output logic                           timeout
`endif
);
  localparam int RW = `FPU_REG_ADDR_WIDTH;
  localparam int OW = `FPU_OP_WIDTH;
  localparam int EW = 3 * RW + OW + 32;
  localparam int AW = $clog2(CMD_DEPTH);
  typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;
  state_t        r_state, w_next;
  logic [EW-1:0] r_mem [CMD_DEPTH];
  logic [AW:0]   r_wp, r_rp;
  logic [EW-1:0] w_head;
  logic          w_empty, w_full, w_push, w_cap, w_free, w_go, w_load, w_to;
  assign w_empty   = r_wp == r_rp;
  assign w_full    = (r_wp[AW] != r_rp[AW]) && (r_wp[AW-1:0] == r_rp[AW-1:0]);
  assign cmd_ready = !w_full;
  assign w_push    = cmd_valid && !w_full;
  assign w_head    = r_mem[r_rp[AW-1:0]];
  assign w_cap     = r_state == RUN && valid;
  assign w_free    = !rsp_valid || rsp_ready;
  // A capture occupies the slot, so RUN may only move on if the core drains it on the same edge
  assign w_go      = (w_cap && rsp_ready) || (r_state == HOLD && w_free);
  assign w_load    = !w_empty && (r_state == IDLE || w_go);
`ifdef FPU_ISSUE_TIMEOUT_EN
  logic [15:0] r_cnt;
  assign w_to = r_state == RUN && !valid && r_cnt == 16'(TIMEOUT_CYCLES - 1);
`else
  assign w_to = 1'b0;
`endif
  always_comb w_next = w_load ? RUN : (w_go || w_to) ? IDLE : w_cap ? HOLD : r_state;
  always_ff @(posedge clk) if (w_push) r_mem[r_wp[AW-1:0]] <= {cmd_x1, cmd_x2, cmd_y, cmd_op, cmd_data};
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_wp      <= '0;
      r_rp      <= '0;
      ready     <= 1'b0;
      {x1, x2, y, operation, in_data} <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_cond  <= 1'b0;
`ifdef FPU_ISSUE_TIMEOUT_EN
      r_cnt     <= '0;
      timeout   <= 1'b0;
`endif
    end else begin
      r_state <= w_next;
      ready   <= w_next == RUN;
      if (w_push) r_wp <= r_wp + 1'b1;
      if (w_load) begin
        r_rp <= r_rp + 1'b1;
        {x1, x2, y, operation, in_data} <= w_head;
      end
      if (w_cap) begin
        rsp_valid <= 1'b1;
        rsp_data  <= out_data;
        rsp_cond  <= cond;
      end else if (rsp_ready) rsp_valid <= 1'b0;
`ifdef FPU_ISSUE_TIMEOUT_EN
      r_cnt <= (w_load || valid) ? '0 : r_state == RUN ? r_cnt + 16'd1 : r_cnt;
      if (w_to) timeout <= 1'b1;
`endif
    end
  end
endmodule

// File: tb/tb_fpu_issue.sv
// tb_fpu_issue: scoreboard bench for fpu_issue with a fixed-latency FPU model.
`ifndef FPU_REG_ADDR_WIDTH
`define FPU_REG_ADDR_WIDTH 5
`endif
`ifndef FPU_OP_WIDTH
`define FPU_OP_WIDTH 4
`endif
module tb_fpu_issue;
  localparam int RW = `FPU_REG_ADDR_WIDTH;
  localparam int OW = `FPU_OP_WIDTH;
  localparam int FW = 3 * RW + OW + 32;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  logic cmd_valid = 1'b0, cmd_ready;
  logic [RW-1:0] cmd_x1 = '0, cmd_x2 = '0, cmd_y = '0, x1, x2, y;
  logic [OW-1:0] cmd_op = '0, operation;
  logic [31:0] cmd_data = '0, in_data, out_data = '0, rsp_data;
  logic ready, valid, m_valid = 1'b0, man_valid = 1'b0, cond = 1'b0;
  logic rsp_valid, rsp_ready = 1'b0, rsp_cond;
`ifdef FPU_ISSUE_TIMEOUT_EN
  logic timeout;
`endif
  assign valid = m_valid | man_valid;
  fpu_issue #(.CMD_DEPTH(2), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_x1(cmd_x1), .cmd_x2(cmd_x2), .cmd_y(cmd_y), .cmd_op(cmd_op), .cmd_data(cmd_data),
    .x1(x1), .x2(x2), .y(y), .operation(operation), .in_data(in_data),
    .ready(ready), .valid(valid), .out_data(out_data), .cond(cond),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_cond(rsp_cond)
`ifdef FPU_ISSUE_TIMEOUT_EN
    , .timeout(timeout)
`endif
  );
  int n_chk = 0, n_pass = 0;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", tag, got, exp);
  endtask
  function automatic logic [32:0] fpu_f(input logic [RW-1:0] a, b, c, input logic [OW-1:0] o, input logic [31:0] d);
    logic [31:0] k;
    k = 32'({a, b, c, o});
    return {^{a, o}, d + k};
  endfunction
  logic [FW-1:0] q_fld[$];
  logic [32:0]   q_exp[$];
  int  lat = 4, cnt = 0;
  bit  fpu_en = 1'b1;
  always @(posedge clk) begin
    #2;
    if (ready && fpu_en && !rst) begin
      if (cnt == lat - 1) begin
        m_valid = 1'b1;
        {cond, out_data} = fpu_f(x1, x2, y, operation, in_data);
        cnt = 0;
      end else begin
        m_valid = 1'b0;
        cnt++;
      end
    end else begin
      m_valid = 1'b0;
      cnt = 0;
    end
  end
  logic [FW-1:0] prev_f = '0;
  bit prev_r = 1'b0, prev_v = 1'b0;
  int n_rdy = 0, n_rsp = 0, n_viol = 0;
  always @(negedge clk) if (!rst) begin
    if (cmd_valid && cmd_ready) begin
      q_fld.push_back({cmd_x1, cmd_x2, cmd_y, cmd_op, cmd_data});
      q_exp.push_back(fpu_f(cmd_x1, cmd_x2, cmd_y, cmd_op, cmd_data));
    end
    if (valid && ready) begin
      if (q_fld.size() == 0) chk("fields_unexpected", 64'd1, 64'd0);
      else chk("fields", 64'({x1, x2, y, operation, in_data}), 64'(q_fld.pop_front()));
    end
    if (rsp_valid && rsp_ready) begin
      n_rsp++;
      if (q_exp.size() == 0) chk("rsp_unexpected", 64'd1, 64'd0);
      else chk("rsp", 64'({rsp_cond, rsp_data}), 64'(q_exp.pop_front()));
    end
    if (ready) n_rdy++;
    if (ready && prev_r && !prev_v && {x1, x2, y, operation, in_data} != prev_f) n_viol++;
    prev_f = {x1, x2, y, operation, in_data};
    prev_r = ready;
    prev_v = valid;
  end
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic wait_accept(input string tag);
    int t = 0;
    bit ok = 1'b0;
    while (!ok && t < 200) begin
      @(negedge clk);
      ok = cmd_ready;
      @(posedge clk);
      #1;
      t++;
    end
    cmd_valid = 1'b0;
    chk(tag, 64'(ok), 64'd1);
  endtask
  task automatic push(input int a, b, c, o, input logic [31:0] d);
    cmd_x1 = RW'(a);
    cmd_x2 = RW'(b);
    cmd_y = RW'(c);
    cmd_op = OW'(o);
    cmd_data = d;
    cmd_valid = 1'b1;
    wait_accept("accept");
  endtask
  task automatic wait_done(input string tag);
    int t = 0;
    while ((q_exp.size() != 0 || ready || rsp_valid) && t < 300) begin
      @(negedge clk);
      t++;
    end
    chk(tag, 64'(t < 300), 64'd1);
  endtask
  task automatic wait_rspv(input string tag);
    int t = 0;
    while (!rsp_valid && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk(tag, 64'(rsp_valid), 64'd1);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    logic [32:0] e1;
    int t;
    cyc(3);
    @(negedge clk);
    chk("rst_ready", 64'(ready), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_rsp", 64'({rsp_cond, rsp_data}), 64'd0);
    chk("rst_cmd_ready", 64'(cmd_ready), 64'd1);
    chk("rst_fields", 64'({x1, x2, y, operation, in_data}), 64'd0);
`ifdef FPU_ISSUE_TIMEOUT_EN
    chk("rst_timeout", 64'(timeout), 64'd0);
`endif
    cyc(1);
    rst = 1'b0;
    rsp_ready = 1'b1;
    cyc(1);
    n_rdy = 0;
    n_rsp = 0;
    push(1, 2, 3, 1, 32'h3f80_0000);
    e1 = fpu_f(cmd_x1, cmd_x2, cmd_y, cmd_op, cmd_data);
    t = 0;
    while (!(valid && ready) && t < 50) begin
      @(negedge clk);
      t++;
    end
    @(negedge clk);
    chk("t1_rsp_valid", 64'(rsp_valid), 64'd1);
    chk("t1_rsp_data", 64'({rsp_cond, rsp_data}), 64'(e1));
    wait_done("t1_done");
    chk("t1_ready_cycles", 64'(n_rdy), 64'd4);
    chk("t1_rsp_count", 64'(n_rsp), 64'd1);
    cyc(1);
    n_rdy = 0;
    n_rsp = 0;
    n_viol = 0;
    push(4, 5, 6, 2, 32'h0000_1111);
    push(7, 8, 9, 3, 32'h0000_2222);
    push(10, 11, 12, 4, 32'hdead_beef);
    wait_done("t2_done");
    chk("t2_ready_cycles", 64'(n_rdy), 64'd12);
    chk("t2_rsp_count", 64'(n_rsp), 64'd3);
    chk("t2_field_changes", 64'(n_viol), 64'd0);
    cyc(1);
    n_rsp = 0;
    rsp_ready = 1'b0;
    push(13, 14, 15, 5, 32'h1234_5678);
    push(16, 17, 18, 6, 32'h8765_4321);
    wait_rspv("t3_first_rsp");
    chk("t3_hold_ready", 64'(ready), 64'd0);
    repeat (3) @(negedge clk);
    chk("t3_hold_still", 64'({ready, rsp_valid}), 64'b01);
    cyc(1);
    rsp_ready = 1'b1;
    cyc(1);
    rsp_ready = 1'b0;
    @(negedge clk);
    chk("t3_second_issued", 64'(ready), 64'd1);
    wait_rspv("t3_second_rsp");
    cyc(1);
    rsp_ready = 1'b1;
    wait_done("t3_done");
    chk("t3_rsp_count", 64'(n_rsp), 64'd2);
    cyc(1);
    n_rsp = 0;
    fpu_en = 1'b0;
    push(19, 20, 21, 7, 32'h0000_000a);
    push(22, 23, 24, 8, 32'h0000_000b);
    push(25, 26, 27, 9, 32'h0000_000c);
    @(negedge clk);
    chk("t4_full", 64'(cmd_ready), 64'd0);
    cmd_x1 = RW'(28);
    cmd_x2 = RW'(29);
    cmd_y = RW'(30);
    cmd_op = OW'(10);
    cmd_data = 32'h0000_000d;
    cmd_valid = 1'b1;
    repeat (3) @(negedge clk);
    chk("t4_still_full", 64'(cmd_ready), 64'd0);
    cyc(1);
    fpu_en = 1'b1;
    wait_accept("t4_accept_fourth");
    wait_done("t4_done");
    chk("t4_rsp_count", 64'(n_rsp), 64'd4);
    cyc(1);
    fpu_en = 1'b0;
    push(3, 1, 4, 1, 32'h0000_5555);
    t = 0;
    while (!ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk("t5_in_run", 64'(ready), 64'd1);
    cyc(1);
    rst = 1'b1;
    cyc(2);
    q_fld.delete();
    q_exp.delete();
    rst = 1'b0;
    man_valid = 1'b1;
    repeat (2) @(negedge clk);
    chk("t5_ready", 64'(ready), 64'd0);
    chk("t5_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("t5_rsp", 64'({rsp_cond, rsp_data}), 64'd0);
    chk("t5_fields", 64'({x1, x2, y, operation, in_data}), 64'd0);
    cyc(1);
    man_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("t5_rsp_stays_low", 64'({ready, rsp_valid}), 64'd0);
    fpu_en = 1'b1;
`ifdef FPU_ISSUE_TIMEOUT_EN
    cyc(1);
    fpu_en = 1'b0;
    n_rdy = 0;
    push(2, 7, 1, 8, 32'h0000_0077);
    t = 0;
    while (!timeout && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("t6_timeout", 64'(timeout), 64'd1);
    chk("t6_ready", 64'(ready), 64'd0);
    chk("t6_run_cycles", 64'(n_rdy), 64'd8);
    chk("t6_no_rsp", 64'(rsp_valid), 64'd0);
    q_fld.delete();
    q_exp.delete();
    repeat (3) @(negedge clk);
    chk("t6_sticky", 64'({timeout, ready}), 64'b10);
    fpu_en = 1'b1;
`endif
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
